instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Sequences the SLC-3 instruction fetch, which consumes the PC register's output. On request it performs MAR <- PC, then PC <- PC+1 by pulsing LD_PC with PCMUX select "PC+1". It holds a memory read for a fixed number of wait cycles and then loads IR from memory data. It sits between the control unit, the PC register/PCMUX logic and the memory interface in the datapath.

Parameters:
MEM_WAIT, 2, number of cycles the read is held before Mem_data is sampled; legal range 1..15; anything else fails an elaboration-time assertion.

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
fetch_req  input  1  control unit request to fetch; sampled only in IDLE
PC_out  input  16  current PC register Q value
Mem_data  input  16  read data from memory
MAR_out  output  16  memory address register
Mem_rd  output  1  memory read enable, active-high
LD_PC  output  1  PC register load strobe
PCMUX_sig  output  2  PCMUX select driven to the PC next-value logic
IR_out  output  16  instruction register
busy  output  1  high whenever state is not IDLE
fetch_done  output  1  one-cycle pulse; IR_out holds the new instruction

Behaviour:
- Reset (sampled at the edge, dominates every other input):
  - state=IDLE, MAR_out=16'h0000, IR_out=16'h0000, wait counter=0.
  - Mem_rd=0, LD_PC=0, busy=0, fetch_done=0, PCMUX_sig=2'b00.
- States: IDLE, READ, DONE.
- IDLE: all strobes 0.
  - If fetch_req=1 at the edge: MAR_out<=PC_out, cnt<=MEM_WAIT-1, go to READ.
  - Otherwise stay in IDLE.
- READ: Mem_rd=1, busy=1.
  - LD_PC=1 in the first READ cycle only. PCMUX_sig=2'b00 (PC+1) in that cycle, so the PC increments concurrently with the memory access.
  - At an edge with cnt!=0: cnt<=cnt-1.
  - At an edge with cnt==0: IR_out<=Mem_data, go to DONE.
- DONE: fetch_done=1, busy=1, Mem_rd=0. The next edge always goes to IDLE; fetch_req is ignored in DONE.
- Latency: request sampled at edge k gives READ in cycles k+1..k+MEM_WAIT and DONE (fetch_done high) in cycle k+MEM_WAIT+1.
  - IR_out is valid from the DONE cycle and is held until the next fetch completes.
- Back-to-back: with fetch_req held high, one fetch completes every MEM_WAIT+2 cycles, because IDLE is always visited for one cycle.
- Capture rules:
  - MAR_out is captured once and is unaffected by PC_out changes during READ, including the change caused by LD_PC.
  - Mem_data is sampled only at the final READ edge; earlier values are ignored.
- PCMUX_sig is constant 2'b00. This block never selects the address-adder or bus sources.
- Counter: 4 bits, unsigned, never wraps (it leaves READ at 0).
- Reset mid-fetch: the next cycle is IDLE with all registers cleared. There is no fetch_done and no further LD_PC; the PC increment already performed is not undone.

Decomposition:
- Shared package slc3_pkg holds:
  - typedef enum fetch_state_t {IDLE, READ, DONE}
  - PCMUX constants PCMUX_PC_PLUS1=2'b00, PCMUX_ADDR=2'b01, PCMUX_BUS=2'b10
  - width constant WORD_W=16
- No sub-module is required. The wait counter stays inline; a separate fetch_wait_counter is not justified at this size.

Test Plan:
1. MEM_WAIT=2, Reset then PC_out=16'h3000, Mem_data=16'h1234, fetch_req pulse sampled at edge 0 -> MAR_out=16'h3000 from cycle 1; LD_PC=1 and PCMUX_sig=00 in cycle 1 only; Mem_rd=1 in cycles 1-2; fetch_done=1 in cycle 3 only; IR_out=16'h1234 in cycle 3.
2. Mem_data=16'hDEAD in cycle 1 and 16'h5A5A in cycle 2 -> IR_out=16'h5A5A.
3. PC_out changes 16'h3000->16'h3001 in cycle 2 -> MAR_out stays 16'h3000 until the next fetch.
4. fetch_req held high, PC_out stepping 16'h3000, 16'h3001, ... -> fetch_done in cycles 3, 7, 11; MAR_out captures 16'h3000, 16'h3001, 16'h3002; exactly one LD_PC per fetch.
5. Reset asserted in cycle 2 of a fetch -> cycle 3 is IDLE with MAR_out=16'h0000, IR_out=16'h0000, busy=0; no fetch_done and no LD_PC.
6. MEM_WAIT=5, request sampled at edge 0 -> Mem_rd high in cycles 1-5, fetch_done in cycle 6 only.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared SLC-3 datapath types and constants used by the fetch sequencer.
package slc3_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] PCMUX_PC_PLUS1 = 2'b00;
  localparam logic [1:0] PCMUX_ADDR     = 2'b01;
  localparam logic [1:0] PCMUX_BUS      = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// SLC-3 instruction fetch sequencer: MAR <- PC, PC <- PC+1, timed memory read,
// then IR <- Mem_data with a one-cycle fetch_done pulse.
module instr_fetch_unit
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              fetch_req,
  input  logic [WORD_W-1:0] PC_out,
  input  logic [WORD_W-1:0] Mem_data,
  output logic [WORD_W-1:0] MAR_out,
  output logic              Mem_rd,
  output logic              LD_PC,
  output logic [1:0]        PCMUX_sig,
  output logic [WORD_W-1:0] IR_out,
  output logic              busy,
  output logic              fetch_done
);

  generate
    if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
      $error("instr_fetch_unit: MEM_WAIT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT - 1);

  fetch_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] ir_q, ir_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          mar_d   = PC_out;
          cnt_d   = CNT_INIT;
          state_d = READ;
        end
      end
      READ: begin
        // Mem_data is only trusted once the full wait has elapsed
        if (cnt_q == 4'd0) begin
          ir_d    = Mem_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter still holds its load value only in the first READ cycle,
  // which is where the single PC increment is issued.
  assign LD_PC      = (state_q == READ) && (cnt_q == CNT_INIT);
  assign Mem_rd     = (state_q == READ);
  assign busy       = (state_q != IDLE);
  assign fetch_done = (state_q == DONE);
  assign PCMUX_sig  = PCMUX_PC_PLUS1;
  assign MAR_out    = mar_q;
  assign IR_out     = ir_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: MEM_WAIT=2 and MEM_WAIT=5 instances share stimulus;
// an elapsed-time model is checked every cycle, plus literal spot checks.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        fetch_req;
  logic [15:0] pc;
  logic [15:0] mdata;

  logic [1:0][15:0] mar, ir;
  logic [1:0][1:0]  pcmux;
  logic [1:0]       rd, ld, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(.MEM_WAIT(2)) u_w2 (
    .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .PC_out(pc), .Mem_data(mdata),
    .MAR_out(mar[0]), .Mem_rd(rd[0]), .LD_PC(ld[0]), .PCMUX_sig(pcmux[0]),
    .IR_out(ir[0]), .busy(busy[0]), .fetch_done(done[0])
  );

  instr_fetch_unit #(.MEM_WAIT(5)) u_w5 (
    .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .PC_out(pc), .Mem_data(mdata),
    .MAR_out(mar[1]), .Mem_rd(rd[1]), .LD_PC(ld[1]), .PCMUX_sig(pcmux[1]),
    .IR_out(ir[1]), .busy(busy[1]), .fetch_done(done[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_e = cycles elapsed since the request edge (0 = idle).
  // 1..W are read cycles, W+1 is the done cycle.
  int          m_e   [2] = '{0, 0};
  logic [15:0] m_mar [2] = '{16'h0, 16'h0};
  logic [15:0] m_ir  [2] = '{16'h0, 16'h0};

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_e[i]   <= 0;
        m_mar[i] <= 16'h0;
        m_ir[i]  <= 16'h0;
      end else if (m_e[i] == 0) begin
        if (fetch_req) begin
          m_e[i]   <= 1;
          m_mar[i] <= pc;
        end
      end else if (m_e[i] <= wait_of(i)) begin
        if (m_e[i] == wait_of(i)) m_ir[i] <= mdata;
        m_e[i] <= m_e[i] + 1;
      end else begin
        m_e[i] <= 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int w;
        int e;
        w = wait_of(i);
        e = m_e[i];
        chk($sformatf("model_mem_rd[%0d]", i), 32'(rd[i]), 32'(e >= 1 && e <= w));
        chk($sformatf("model_ld_pc[%0d]", i), 32'(ld[i]), 32'(e == 1));
        chk($sformatf("model_done[%0d]", i), 32'(done[i]), 32'(e == w + 1));
        chk($sformatf("model_busy[%0d]", i), 32'(busy[i]), 32'(e != 0));
        chk($sformatf("model_pcmux[%0d]", i), 32'(pcmux[i]), 32'(2'b00));
        chk($sformatf("model_mar[%0d]", i), 32'(mar[i]), 32'(m_mar[i]));
        chk($sformatf("model_ir[%0d]", i), 32'(ir[i]), 32'(m_ir[i]));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_e[0] != 0 || m_e[1] != 0) && n < 30) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(n < 30), 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    logic [15:0] rd_mask [2];
    logic [15:0] dn_mask [2];
    logic [15:0] done4;
    int          ld4;
    logic [15:0] mar_at_done [3];
    int          nd;

    Reset = 1'b1; fetch_req = 1'b0; pc = 16'h0; mdata = 16'h0;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_mar", 32'(mar[i]), 32'h0);
      chk("reset_ir", 32'(ir[i]), 32'h0);
      chk("reset_busy", 32'(busy[i]), 32'h0);
      chk("reset_done", 32'(done[i]), 32'h0);
      chk("reset_rd", 32'(rd[i]), 32'h0);
    end
    chk_en = 1'b1;

    // Test 1 / 6: single request, latency for both MEM_WAIT values
    Reset = 1'b0; pc = 16'h3000; mdata = 16'h1234; fetch_req = 1'b1;
    rd_mask = '{16'h0, 16'h0};
    dn_mask = '{16'h0, 16'h0};
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (c == 1) fetch_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
        rd_mask[i][c] = rd[i];
        dn_mask[i][c] = done[i];
      end
      if (c == 1) begin
        chk("t1_mar_c1", 32'(mar[0]), 32'h3000);
        chk("t1_ldpc_c1", 32'(ld[0]), 32'h1);
        chk("t1_pcmux_c1", 32'(pcmux[0]), 32'h0);
      end
      if (c == 2) chk("t1_ldpc_c2", 32'(ld[0]), 32'h0);
      if (c == 3) chk("t1_ir_c3", 32'(ir[0]), 32'h1234);
      if (c == 6) chk("t6_ir_c6", 32'(ir[1]), 32'h1234);
    end
    chk("t1_rd_cycles", 32'(rd_mask[0]), 32'h0006);
    chk("t1_done_cycles", 32'(dn_mask[0]), 32'h0008);
    chk("t6_rd_cycles", 32'(rd_mask[1]), 32'h003E);
    chk("t6_done_cycles", 32'(dn_mask[1]), 32'h0040);
    wait_idle();

    // Test 2 / 3: only the last-edge Mem_data counts; MAR ignores PC moves
    pc = 16'h3000; mdata = 16'h1111; fetch_req = 1'b1;
    @(negedge Clk); fetch_req = 1'b0; mdata = 16'hDEAD;
    @(negedge Clk); mdata = 16'h5A5A; pc = 16'h3001;
    @(negedge Clk);
    chk("t2_ir", 32'(ir[0]), 32'h5A5A);
    chk("t2_done", 32'(done[0]), 32'h1);
    chk("t3_mar_done", 32'(mar[0]), 32'h3000);
    wait_idle();
    chk("t3_mar_held", 32'(mar[0]), 32'h3000);
    chk("t2_ir_held", 32'(ir[1]), 32'h5A5A);

    // Test 5: reset during the second READ cycle
    pc = 16'h4000; mdata = 16'h7777; fetch_req = 1'b1;
    @(negedge Clk); fetch_req = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t5_busy", 32'(busy[i]), 32'h0);
      chk("t5_mar", 32'(mar[i]), 32'h0);
      chk("t5_ir", 32'(ir[i]), 32'h0);
      chk("t5_done", 32'(done[i]), 32'h0);
      chk("t5_ldpc", 32'(ld[i]), 32'h0);
    end
    repeat (8) @(negedge Clk);
    chk("t5_still_idle", 32'(busy), 32'h0);

    // Test 4: back-to-back with the bench acting as the PC register
    pc = 16'h3000; fetch_req = 1'b1;
    done4 = 16'h0; ld4 = 0; nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      done4[c] = done[0];
      if (done[0] && nd < 3) begin
        mar_at_done[nd] = mar[0];
        nd++;
      end
      if (ld[0]) begin
        ld4++;
        pc = pc + 16'h1;
      end
      if (c == 12) fetch_req = 1'b0;
    end
    chk("t4_done_cycles", 32'(done4), 32'h0888);
    chk("t4_ldpc_count", 32'(ld4), 32'd3);
    chk("t4_fetch_count", 32'(nd), 32'd3);
    chk("t4_mar0", 32'(mar_at_done[0]), 32'h3000);
    chk("t4_mar1", 32'(mar_at_done[1]), 32'h3001);
    chk("t4_mar2", 32'(mar_at_done[2]), 32'h3002);
    wait_idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
